// File: rtl/gold_scrambler_gen.sv
// gold_scrambler_gen
// Multi-lane Gold-sequence randomizer (CCSDS / DVB-S2 style). Emits LANES
// consecutive 2-bit scrambling symbols R(i) per beat from a runtime-selected
// Gold code index n. Only the x/y 18-bit LFSR state is stepped; no symbol
// data passes through this block.
//
// Ports:
//   i_clk          clock
//   i_reset        synchronous, active-high reset
//   i_start        one-cycle pulse: latch i_gold_n / i_frame_beats, (re)seed
//   i_gold_n       number of x steps applied before the first symbol
//   i_frame_beats  beats per frame, 0 = unbounded (no EOF, no reinit)
//   i_ready        downstream accepts the current beat
//   o_valid        o_r holds a valid beat
//   o_r            lane k at [2k+1:2k] = R(i+k), lane 0 earliest
//   o_sof / o_eof  first / last beat of a frame, qualified by o_valid
//   o_busy         high while seeding or running
//
// Handshake: a beat transfers on a cycle where o_valid && i_ready at the
// rising edge. While o_valid is high and i_ready is low, o_r/o_sof/o_eof are
// held stable. o_valid never drops without a transfer except on i_start or
// reset, which discard the pending beat.
module gold_scrambler_gen #(
  parameter int LANES   = 1,
  parameter int BEATS_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [17:0]          i_gold_n,
  input  logic [BEATS_W-1:0]   i_frame_beats,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [2*LANES-1:0]   o_r,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [17:0] X_INIT = 18'h00001;
  localparam logic [17:0] Y_INIT = 18'h3FFFF;

  state_e             state_q, state_d;
  logic [17:0]        x_q, x_d;
  logic [17:0]        y_q, y_d;
  logic [17:0]        xs_q, xs_d;
  logic [17:0]        seed_cnt_q, seed_cnt_d;
  logic [BEATS_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEATS_W-1:0] frame_beats_q, frame_beats_d;

  // Unrolled LFSR chain: index k is the registered state advanced k steps.
  logic [17:0]        x_lane [LANES+1];
  logic [17:0]        y_lane [LANES+1];
  logic [2*LANES-1:0] r_all;
  logic               run;
  logic               last_beat;
  logic               xfer;

  function automatic logic [17:0] step_x(input logic [17:0] x);
    return {x[7] ^ x[0], x[17:1]};
  endfunction

  function automatic logic [17:0] step_y(input logic [17:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  function automatic logic [1:0] gold_sym(input logic [17:0] x, input logic [17:0] y);
    logic hi;
    logic lo;
    hi = (x[4] ^ x[6] ^ x[15]) ^
         (y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^ y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15]);
    lo = x[0] ^ y[0];
    return {hi, lo};
  endfunction

  always_comb begin
    x_lane[0] = x_q;
    y_lane[0] = y_q;
    r_all     = '0;
    for (int k = 0; k < LANES; k++) begin
      x_lane[k+1]      = step_x(x_lane[k]);
      y_lane[k+1]      = step_y(y_lane[k]);
      r_all[2*k +: 2]  = gold_sym(x_lane[k], y_lane[k]);
    end
  end

  assign run       = (state_q == ST_RUN);
  assign last_beat = (frame_beats_q != '0) &&
                     (beat_cnt_q == frame_beats_q - {{(BEATS_W-1){1'b0}}, 1'b1});
  assign xfer      = run && i_ready;

  assign o_valid = run;
  assign o_r     = run ? r_all : '0;
  assign o_sof   = run && (beat_cnt_q == '0);
  assign o_eof   = run && last_beat;
  assign o_busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    xs_d          = xs_q;
    seed_cnt_d    = seed_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    frame_beats_d = frame_beats_q;

    if (i_start) begin
      // Restart overrides everything, including a same-cycle transfer.
      frame_beats_d = i_frame_beats;
      x_d           = X_INIT;
      y_d           = Y_INIT;
      seed_cnt_d    = i_gold_n;
      state_d       = ST_SEED;
    end else begin
      case (state_q)
        ST_SEED: begin
          if (seed_cnt_q != '0) begin
            x_d        = step_x(x_q);
            seed_cnt_d = seed_cnt_q - 18'd1;
          end else begin
            xs_d       = x_q;
            beat_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (last_beat) begin
              // Reinit for the next frame so the following beat is R0 again.
              x_d        = xs_q;
              y_d        = Y_INIT;
              beat_cnt_d = '0;
            end else begin
              x_d        = x_lane[LANES];
              y_d        = y_lane[LANES];
              beat_cnt_d = beat_cnt_q + {{(BEATS_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      x_q           <= X_INIT;
      y_q           <= Y_INIT;
      xs_q          <= X_INIT;
      seed_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      frame_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      xs_q          <= xs_d;
      seed_cnt_q    <= seed_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_beats_q <= frame_beats_d;
    end
  end

endmodule
